// File: rtl/qos_channel_arbiter_pkg.sv
// Shared constants, FSM state type and priority-pick helper for the QoS
// channel arbiter.
package qos_pkg;

    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int TIMER_W = 20;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        PENDING = 2'd1,
        SWITCH  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic            found;
        logic [CH_W-1:0] ch;
    } prio_pick_t;

    // Walks the priority list from [1:0] upward and returns the first qualified channel.
    function automatic prio_pick_t prio_pick(input logic [NUM_CH*CH_W-1:0] prio,
                                             input logic [NUM_CH-1:0]      qual);
        prio_pick_t      pick;
        logic [CH_W-1:0] cand;
        pick = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = prio[k*CH_W +: CH_W];
            if (!pick.found && qual[cand]) begin
                pick.found = 1'b1;
                pick.ch    = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/qos_channel_arbiter_if.sv
// Configuration, presence, packet-framing and status bundle between the
// presence detectors / register block and the channel arbiter.
interface qos_channel_arbiter_if;
    import qos_pkg::*;

    logic [NUM_CH-1:0]       presence;
    logic                    fallback_enable;
    logic                    manual_enable;
    logic [CH_W-1:0]         manual_channel;
    logic [NUM_CH*CH_W-1:0]  channel_priority;
    logic [TIMER_W-1:0]      reset_timer;
    logic                    pkt_boundary;
    logic                    out_idle;
    logic                    cnt_clear;

    logic [CH_W-1:0]         active_ch;
    logic                    switch_pulse;
    logic                    pending;
    logic                    no_signal;
    logic [NUM_CH-1:0]       qualified;
    logic [NUM_CH*CNT_W-1:0] loss_cnt;

    modport master (
        output presence, fallback_enable, manual_enable, manual_channel,
               channel_priority, reset_timer, pkt_boundary, out_idle, cnt_clear,
        input  active_ch, switch_pulse, pending, no_signal, qualified, loss_cnt
    );

    modport slave (
        input  presence, fallback_enable, manual_enable, manual_channel,
               channel_priority, reset_timer, pkt_boundary, out_idle, cnt_clear,
        output active_ch, switch_pulse, pending, no_signal, qualified, loss_cnt
    );

endinterface

// File: rtl/qos_channel_arbiter_qualifier.sv
// Per-channel presence qualifier: hold-off counter, qualified flag and a
// saturating loss counter driven by the registered falling edge of presence.
module qos_presence_qualifier
    import qos_pkg::*;
(
    input  logic               rclk,
    input  logic               rst_n,
    input  logic               presence_i,
    input  logic [TIMER_W-1:0] reset_timer_i,
    input  logic               cnt_clear_i,
    output logic               qualified_o,
    output logic [CNT_W-1:0]   loss_cnt_o
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic               qualified_q, qualified_d;
    logic               presence_q;
    logic [CNT_W-1:0]   loss_q, loss_d;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            qualified_q <= 1'b0;
            presence_q  <= 1'b0;
            loss_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            qualified_q <= qualified_d;
            presence_q  <= presence_i;
            loss_q      <= loss_d;
        end
    end

    // The >= test lets a lowered hold-off qualify a channel already past the new limit.
    always_comb begin
        cnt_d       = cnt_q;
        qualified_d = qualified_q;
        loss_d      = loss_q;
        if (!presence_i) begin
            cnt_d       = '0;
            qualified_d = 1'b0;
        end else if (cnt_q < reset_timer_i) begin
            cnt_d = cnt_q + TIMER_W'(1);
        end else begin
            qualified_d = 1'b1;
        end
        if (cnt_clear_i) begin
            loss_d = '0;
        end else if (presence_q && !presence_i && (loss_q != '1)) begin
            loss_d = loss_q + CNT_W'(1);
        end
    end

    assign qualified_o = qualified_q;
    assign loss_cnt_o  = loss_q;

endmodule

// File: rtl/qos_channel_arbiter.sv
// Chooses the channel feeding the QoS output mux and commits each change
// only when the output is idle or at a packet boundary.
module qos_channel_arbiter
    import qos_pkg::*;
(
    input  logic rclk,
    input  logic rst_n,
    qos_channel_arbiter_if.slave bus
);

    logic [NUM_CH-1:0]       qualified_w;
    logic [NUM_CH*CNT_W-1:0] loss_cnt_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_qual
        qos_presence_qualifier u_qual (
            .rclk          (rclk),
            .rst_n         (rst_n),
            .presence_i    (bus.presence[i]),
            .reset_timer_i (bus.reset_timer),
            .cnt_clear_i   (bus.cnt_clear),
            .qualified_o   (qualified_w[i]),
            .loss_cnt_o    (loss_cnt_w[i*CNT_W +: CNT_W])
        );
    end

    arb_state_t      state_q, state_d;
    logic [CH_W-1:0] active_ch_q, active_ch_d;
    prio_pick_t      hp;
    logic            use_hp;
    logic [CH_W-1:0] target;

    // With nothing qualified the highest-priority pick holds the current channel.
    always_comb begin
        hp     = prio_pick(bus.channel_priority, qualified_w);
        use_hp = 1'b0;
        target = bus.channel_priority[CH_W-1:0];
        if (bus.manual_enable) begin
            target = bus.manual_channel;
            use_hp = bus.fallback_enable && !qualified_w[bus.manual_channel];
        end else if (bus.fallback_enable) begin
            use_hp = 1'b1;
        end
        if (use_hp) begin
            target = hp.found ? hp.ch : active_ch_q;
        end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOCKED;
            active_ch_q <= '0;
        end else begin
            state_q     <= state_d;
            active_ch_q <= active_ch_d;
        end
    end

    // active_ch moves on the edge entering SWITCH so the pulse coincides with the new channel.
    always_comb begin
        state_d     = state_q;
        active_ch_d = active_ch_q;
        case (state_q)
            LOCKED: begin
                if (target != active_ch_q) state_d = PENDING;
            end
            PENDING: begin
                if (target == active_ch_q) begin
                    state_d = LOCKED;
                end else if (bus.pkt_boundary || bus.out_idle) begin
                    state_d     = SWITCH;
                    active_ch_d = target;
                end
            end
            SWITCH:  state_d = LOCKED;
            default: state_d = LOCKED;
        endcase
    end

    assign bus.active_ch    = active_ch_q;
    assign bus.switch_pulse = (state_q == SWITCH);
    assign bus.pending      = (state_q == PENDING);
    assign bus.no_signal    = ~|qualified_w;
    assign bus.qualified    = qualified_w;
    assign bus.loss_cnt     = loss_cnt_w;

endmodule
